// File: rtl/up_counter.sv
// up_counter: free-running WIDTH-bit binary up-counter with a synchronous load
// and a count enable. It supplies the sample/address index for the FIR datapath.
// The count wraps modulo 2^WIDTH with no carry flag. COUNT comes straight from
// the register, so the output has no combinational path from the inputs.

module up_counter #(
   parameter int unsigned      WIDTH      = 14,
   parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic             LOAD,
   output logic [WIDTH-1:0] COUNT
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next-count selection: load beats enable, and enable beats hold.
   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (LOAD) begin
         count_d = LOAD_VALUE;
      end else if (ENABLE) begin
         // The carry-out is dropped on purpose, so 2^WIDTH-1 rolls over to 0.
         count_d = count_q + 1'b1;
      end
   end

   // Count register with asynchronous clear. Reset forces 0 at once, with no clock edge needed.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of count_q.
         count_q <= count_d;
      end
   end

   assign COUNT = count_q;

endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: directed self-checking bench for up_counter. Each scenario task
// drives its own stimulus and compares COUNT with values computed by hand. The
// wrap scenario also uses a small modulo-2^14 golden model.

`timescale 1ns/1ps

module tb_up_counter;

   localparam int unsigned WIDTH = 14;

   logic             CLK;
   logic             RESET;
   logic             ENABLE;
   logic             LOAD;
   logic [WIDTH-1:0] COUNT;

   logic             clk_run;
   int               checks;
   int               failures;

   up_counter #(
      .WIDTH      (WIDTH),
      .LOAD_VALUE ('0)
   ) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .ENABLE (ENABLE),
      .LOAD   (LOAD),
      .COUNT  (COUNT)
   );

   // Clock generator that can be held. This lets one scenario prove that reset acts without an edge.
   initial CLK = 1'b0;
   always begin
      #5;
      if (clk_run) CLK = ~CLK;
   end

   // Watchdog so that the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // Advance one rising edge, then settle 1 ns past it to sample and drive.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_count(input string name, input logic [WIDTH-1:0] exp);
      checks++;
      if (COUNT !== exp) begin
         failures++;
         $display("FAIL %s: COUNT=%0d expected=%0d", name, COUNT, exp);
      end
   endtask

   // Load the counter to LOAD_VALUE (0) and leave the controls idle.
   task automatic do_load();
      LOAD   = 1'b1;
      ENABLE = 1'b0;
      step();
      LOAD   = 1'b0;
   endtask

   // Assert reset with the clock stopped. COUNT must clear at once and stay 0 while disabled.
   task automatic test_reset();
      clk_run = 1'b0;
      #3;
      RESET = 1'b1;
      #1;
      expect_count("reset_immediate", 14'd0);
      #2;
      RESET   = 1'b0;
      clk_run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_count("reset_idle_hold", 14'd0);
      end
   endtask

   // A single load edge gives 0, and each enabled edge after it adds 1.
   task automatic test_load_count();
      do_load();
      expect_count("load_zero", 14'd0);
      ENABLE = 1'b1;
      step(); expect_count("count_1", 14'd1);
      step(); expect_count("count_2", 14'd2);
      step(); expect_count("count_3", 14'd3);
      step(); expect_count("count_4", 14'd4);
      ENABLE = 1'b0;
   endtask

   // 16387 enabled edges from 0, run against a golden model. This crosses the 2^14 wrap.
   task automatic test_wrap();
      logic [WIDTH-1:0] model;
      int               shown;
      shown = 0;
      do_load();
      model  = '0;
      ENABLE = 1'b1;
      for (int i = 1; i <= 16387; i++) begin
         step();
         model = model + 1'b1;
         checks++;
         if (COUNT !== model) begin
            failures++;
            if (shown < 8) begin
               $display("FAIL wrap_model edge %0d: COUNT=%0d expected=%0d", i, COUNT, model);
               shown++;
            end
         end
         if (i == 16383) expect_count("wrap_max", 14'd16383);
         if (i == 16384) expect_count("wrap_zero", 14'd0);
      end
      expect_count("wrap_end_3", 14'd3);
      ENABLE = 1'b0;
   endtask

   // Count to 5, hold for 3 disabled edges, then re-enable to 6.
   task automatic test_hold();
      do_load();
      ENABLE = 1'b1;
      repeat (5) step();
      expect_count("hold_reach_5", 14'd5);
      ENABLE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_count("hold_5", 14'd5);
      end
      ENABLE = 1'b1;
      step();
      expect_count("hold_resume_6", 14'd6);
      ENABLE = 1'b0;
   endtask

   // With LOAD and ENABLE high together at COUNT=100, load wins and the result is 0.
   task automatic test_load_priority();
      do_load();
      ENABLE = 1'b1;
      repeat (100) step();
      expect_count("prio_reach_100", 14'd100);
      LOAD = 1'b1;
      step();
      expect_count("prio_load_wins", 14'd0);
      LOAD = 1'b0;
      step();
      expect_count("prio_after_load", 14'd1);
      ENABLE = 1'b0;
   endtask

   // Assert reset at 1234 between edges, then resume counting from 0 after release.
   task automatic test_async_reset();
      do_load();
      ENABLE = 1'b1;
      repeat (1234) step();
      expect_count("areset_reach_1234", 14'd1234);
      #1;
      RESET = 1'b1;
      #1;
      expect_count("areset_immediate", 14'd0);
      step();
      expect_count("areset_held", 14'd0);
      #2;
      RESET = 1'b0;
      step();
      expect_count("areset_resume_1", 14'd1);
      ENABLE = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clk_run  = 1'b1;
      RESET    = 1'b0;
      ENABLE   = 1'b0;
      LOAD     = 1'b0;

      test_reset();
      test_load_count();
      test_wrap();
      test_hold();
      test_load_priority();
      test_async_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
